// File: rtl/mac_pkg.sv
// Shared types and defaults for the multiply-accumulate sequencer.
package mac_pkg;

  localparam int MAC_OP_W      = 8;
  localparam int MAC_ACC_W     = 20;
  localparam int MAC_TERMS_MAX = 15;
  localparam int MAC_CNT_W     = $clog2(MAC_TERMS_MAX + 1);

  // Sequencer states; the encoding is visible on the seq_state debug port.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_WAIT_OP  = 3'd2,
    S_LOAD     = 3'd3,
    S_BEGIN    = 3'd4,
    S_WAIT_MUL = 3'd5,
    S_ACCUM    = 3'd6,
    S_DONE     = 3'd7
  } mac_seq_state_t;

  // Busy covers every state in which a job is in flight.
  function automatic logic is_busy_state(input mac_seq_state_t s);
    return !((s == S_IDLE) || (s == S_DONE));
  endfunction

endpackage

// File: rtl/mac_accumulator.sv
// Accumulator register with synchronous clear, enable and a sticky carry-out.
// The sum wraps modulo 2^ACC_W; carry remembers any wrap until cleared.
module mac_accumulator #(
  parameter int ACC_W = 20,
  parameter int ADD_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             clear_carry,
  input  logic             enable,
  input  logic [ADD_W-1:0] addend,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] addend_ext;
  logic [ACC_W:0] total;

  // One extra bit on the adder captures the carry out of the top sum bit.
  always_comb begin
    addend_ext = {{(ACC_W + 1 - ADD_W){1'b0}}, addend};
    total      = {1'b0, sum} + addend_ext;
  end

  // Clock-enabled sum and sticky carry; clear takes priority over accumulate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum   <= '0;
      carry <= 1'b0;
    end else if (clear) begin
      sum   <= '0;
      carry <= 1'b0;
    end else if (clear_carry) begin
      carry <= 1'b0;
    end else if (enable) begin
      sum   <= total[ACC_W-1:0];
      carry <= carry | total[ACC_W];
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// Sequencer for the shift-add multiply-accumulate datapath.
// Handshake: an operand pair transfers on a rising clock edge where
// op_valid and op_ready are both high; op_ready is high only in WAIT_OP.
// All control outputs come straight from flops (decoded from the next state)
// so mul_begin and friends cannot glitch.
module mac_sequencer import mac_pkg::*; #(
  parameter int N_TERMS = 9,
  parameter int OP_W    = MAC_OP_W,
  parameter int ACC_W   = MAC_ACC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  output logic              mul_begin,
  input  logic              mul_idle,
  input  logic [2*OP_W-1:0] mult_res,
  output logic [ACC_W-1:0]  result,
  output logic              acc_carry,
  output logic              result_valid,
  output logic              done,
  output logic              busy,
  output logic [2:0]        seq_state
);

  mac_seq_state_t         state_q;
  mac_seq_state_t         state_d;
  logic [MAC_CNT_W-1:0]   count_q;
  logic                   guard_q;
  logic                   abort_hit;
  logic                   acc_clear;
  logic                   acc_en;
  logic                   capture;

  assign seq_state = state_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and the strobes that steer the datapath.
  always_comb begin
    state_d   = state_q;
    abort_hit = abort && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:     if (start && !abort) state_d = S_CLEAR;
      S_CLEAR:    state_d = S_WAIT_OP;
      S_WAIT_OP:  if (op_valid && op_ready) state_d = S_LOAD;
      S_LOAD:     state_d = S_BEGIN;
      S_BEGIN:    state_d = S_WAIT_MUL;
      // The first WAIT_MUL cycle ignores mul_idle: the multiplier only
      // drops End_mul one cycle after it sees the begin strobe.
      S_WAIT_MUL: if (guard_q && mul_idle) state_d = S_ACCUM;
      S_ACCUM:    state_d = (count_q == '0) ? S_DONE : S_WAIT_OP;
      S_DONE:     if (start) state_d = S_CLEAR;
      default:    state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
    // CLEAR is only ever entered from IDLE or DONE, so this is the start event.
    acc_clear = (state_d == S_CLEAR);
    acc_en    = (state_q == S_ACCUM) && !abort_hit;
    capture   = (state_q == S_WAIT_OP) && op_valid && op_ready && !abort_hit;
  end

  // Registered control outputs, term counter, guard flag and operand latches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_ready     <= 1'b0;
      mul_begin    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      count_q      <= '0;
      guard_q      <= 1'b0;
    end else begin
      op_ready     <= (state_d == S_WAIT_OP);
      mul_begin    <= (state_d == S_BEGIN);
      busy         <= is_busy_state(state_d);
      done         <= (state_q == S_ACCUM) && (state_d == S_DONE);
      result_valid <= (state_d == S_DONE);
      guard_q      <= (state_q == S_WAIT_MUL);
      if (capture) begin
        mul_a <= op_a;
        mul_b <= op_b;
      end
      if (abort_hit)
        count_q <= '0;
      else if (acc_clear)
        count_q <= MAC_CNT_W'(N_TERMS - 1);
      else if (acc_en && (count_q != '0))
        count_q <= count_q - 1'b1;
    end
  end

  mac_accumulator #(
    .ACC_W (ACC_W),
    .ADD_W (2 * OP_W)
  ) u_acc (
    .clock       (clock),
    .reset       (reset),
    .clear       (acc_clear),
    .clear_carry (abort_hit),
    .enable      (acc_en),
    .addend      (mult_res),
    .sum         (result),
    .carry       (acc_carry)
  );

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: three instances (9 terms / 20 bits,
// 15 terms / 20 bits, 2 terms / 16 bits), each with a variable-latency
// shift-add multiplier model.
module tb_mac_sequencer;
  import mac_pkg::*;

  logic        clock;
  logic        reset;
  logic        start        [3];
  logic        abort        [3];
  logic        op_valid     [3];
  logic        op_ready     [3];
  logic [7:0]  op_a         [3];
  logic [7:0]  op_b         [3];
  logic [7:0]  mul_a        [3];
  logic [7:0]  mul_b        [3];
  logic        mul_begin    [3];
  logic        mul_idle     [3];
  logic [15:0] mult_res     [3];
  logic [19:0] result       [3];
  logic [15:0] result16;
  logic        acc_carry    [3];
  logic        result_valid [3];
  logic        done         [3];
  logic        busy         [3];
  logic [2:0]  seq_state    [3];
  int          lat          [3];
  int          begin_cnt    [3];
  int          done_cnt     [3];
  int          n_checks;
  int          n_fail;

  assign result[2] = {4'h0, result16};

  // Clock block.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  mac_sequencer #(.N_TERMS(9), .OP_W(8), .ACC_W(20)) dut0 (
    .clock(clock), .reset(reset), .start(start[0]), .abort(abort[0]),
    .op_valid(op_valid[0]), .op_ready(op_ready[0]), .op_a(op_a[0]), .op_b(op_b[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_begin(mul_begin[0]), .mul_idle(mul_idle[0]),
    .mult_res(mult_res[0]), .result(result[0]), .acc_carry(acc_carry[0]),
    .result_valid(result_valid[0]), .done(done[0]), .busy(busy[0]), .seq_state(seq_state[0])
  );

  mac_sequencer #(.N_TERMS(15), .OP_W(8), .ACC_W(20)) dut1 (
    .clock(clock), .reset(reset), .start(start[1]), .abort(abort[1]),
    .op_valid(op_valid[1]), .op_ready(op_ready[1]), .op_a(op_a[1]), .op_b(op_b[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_begin(mul_begin[1]), .mul_idle(mul_idle[1]),
    .mult_res(mult_res[1]), .result(result[1]), .acc_carry(acc_carry[1]),
    .result_valid(result_valid[1]), .done(done[1]), .busy(busy[1]), .seq_state(seq_state[1])
  );

  mac_sequencer #(.N_TERMS(2), .OP_W(8), .ACC_W(16)) dut2 (
    .clock(clock), .reset(reset), .start(start[2]), .abort(abort[2]),
    .op_valid(op_valid[2]), .op_ready(op_ready[2]), .op_a(op_a[2]), .op_b(op_b[2]),
    .mul_a(mul_a[2]), .mul_b(mul_b[2]), .mul_begin(mul_begin[2]), .mul_idle(mul_idle[2]),
    .mult_res(mult_res[2]), .result(result16), .acc_carry(acc_carry[2]),
    .result_valid(result_valid[2]), .done(done[2]), .busy(busy[2]), .seq_state(seq_state[2])
  );

  // Multiplier model: End_mul drops one cycle after begin, stays low for
  // lat cycles, and the product only appears when End_mul rises again.
  // Pulse counters for mul_begin rising edges and done samples.
  for (genvar g = 0; g < 3; g++) begin : gen_mul
    logic        idle_r;
    logic        armed;
    int          cnt;
    logic [15:0] pend;
    logic [15:0] res_r;
    logic        begin_prev;
    int          bcnt;
    int          dcnt;

    assign mul_idle[g]  = idle_r;
    assign mult_res[g]  = res_r;
    assign begin_cnt[g] = bcnt;
    assign done_cnt[g]  = dcnt;

    always @(posedge clock or posedge reset) begin
      if (reset) begin
        idle_r <= 1'b1;
        armed  <= 1'b0;
        cnt    <= 0;
        pend   <= '0;
        res_r  <= '0;
      end else if (mul_begin[g]) begin
        armed <= 1'b1;
        pend  <= 16'(mul_a[g]) * 16'(mul_b[g]);
      end else if (armed) begin
        armed  <= 1'b0;
        idle_r <= 1'b0;
        cnt    <= lat[g] - 1;
      end else if (!idle_r) begin
        if (cnt == 0) begin
          idle_r <= 1'b1;
          res_r  <= pend;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end

    initial begin
      bcnt       = 0;
      dcnt       = 0;
      begin_prev = 1'b0;
      forever begin
        @(negedge clock);
        if (mul_begin[g] && !begin_prev) bcnt = bcnt + 1;
        begin_prev = mul_begin[g];
        if (done[g]) dcnt = dcnt + 1;
      end
    end
  end

  // Scoreboard comparison point.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: one start pulse sampled at the next rising edge.
  task automatic start_job(input int k);
    start[k] = 1'b1;
    @(negedge clock);
    start[k] = 1'b0;
  endtask

  // Driver: present one operand pair and hold it until it is accepted.
  task automatic feed_pair(input int k, input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    lat[k] = $urandom_range(1, 40);
    while (op_ready[k] !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    check($sformatf("op_ready_wait_k%0d", k), 32'(t < 200), 32'd1);
    op_a[k]     = a;
    op_b[k]     = b;
    op_valid[k] = 1'b1;
    @(negedge clock);
    op_valid[k] = 1'b0;
    op_a[k]     = 8'($urandom_range(0, 255));
    op_b[k]     = 8'($urandom_range(0, 255));
  endtask

  // Bounded wait for a given state; the final compare doubles as the timeout check.
  task automatic wait_state(input int k, input mac_seq_state_t st, input string tag);
    int t;
    t = 0;
    while (seq_state[k] !== 3'(st) && t < 200) begin
      @(negedge clock);
      t++;
    end
    check(tag, 32'(seq_state[k]), 32'(st));
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int b0;
  int d0;

  // Directed stimulus.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; abort[k] = 1'b0; op_valid[k] = 1'b0;
      op_a[k] = '0; op_b[k] = '0; lat[k] = 5;
    end
    repeat (2) @(negedge clock);

    // Reset values on every instance.
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_result_k%0d", k), 32'(result[k]), 0);
      check($sformatf("rst_outs_k%0d", k),
            32'({acc_carry[k], result_valid[k], done[k], busy[k], op_ready[k], mul_begin[k]}), 0);
      check($sformatf("rst_mul_ops_k%0d", k), 32'({mul_a[k], mul_b[k]}), 0);
      check($sformatf("rst_state_k%0d", k), 32'(seq_state[k]), 32'(S_IDLE));
    end
    reset = 1'b0;
    @(negedge clock);

    // Nine pairs (i+2)*(i+3) -> 438, with an ignored op_valid and repeat start.
    b0 = begin_cnt[0];
    d0 = done_cnt[0];
    start_job(0);
    check("t1_clear_state", 32'(seq_state[0]), 32'(S_CLEAR));
    for (int i = 0; i < 9; i++) begin
      if (i == 1) begin
        wait_state(0, S_WAIT_OP, "t1_reach_wait_op");
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        check("t1_repeat_start_state", 32'(seq_state[0]), 32'(S_WAIT_OP));
        check("t1_repeat_start_busy", 32'(busy[0]), 1);
      end
      feed_pair(0, 8'(i + 2), 8'(i + 3));
      if (i == 0) begin
        wait_state(0, S_WAIT_MUL, "t1_reach_wait_mul");
        op_a[0] = 8'hEE; op_b[0] = 8'hDD; op_valid[0] = 1'b1;
        @(negedge clock);
        op_valid[0] = 1'b0;
        check("t1_no_capture_a", 32'(mul_a[0]), 2);
        check("t1_no_capture_b", 32'(mul_b[0]), 3);
      end
    end
    wait_state(0, S_DONE, "t1_reach_done");
    check("t1_done_pulse_high", 32'(done[0]), 1);
    @(negedge clock);
    check("t1_result", 32'(result[0]), 438);
    check("t1_carry", 32'(acc_carry[0]), 0);
    check("t1_result_valid", 32'(result_valid[0]), 1);
    check("t1_busy", 32'(busy[0]), 0);
    check("t1_done_one_cycle", 32'(done[0]), 0);
    check("t1_done_count", 32'(done_cnt[0] - d0), 1);
    check("t1_begin_count", 32'(begin_cnt[0] - b0), 9);

    // Restart from DONE clears the sum, then abort in WAIT_MUL of the 4th term.
    d0 = done_cnt[0];
    start_job(0);
    check("t2_clear_state", 32'(seq_state[0]), 32'(S_CLEAR));
    check("t2_clear_result", 32'(result[0]), 0);
    check("t2_clear_valid", 32'(result_valid[0]), 0);
    for (int i = 0; i < 4; i++) feed_pair(0, 8'(i + 2), 8'(i + 3));
    wait_state(0, S_WAIT_MUL, "t2_reach_wait_mul");
    abort[0] = 1'b1;
    @(negedge clock);
    abort[0] = 1'b0;
    check("t2_abort_state", 32'(seq_state[0]), 32'(S_IDLE));
    check("t2_abort_valid", 32'(result_valid[0]), 0);
    check("t2_abort_busy", 32'(busy[0]), 0);
    check("t2_abort_result_held", 32'(result[0]), 38);
    check("t2_abort_carry", 32'(acc_carry[0]), 0);
    repeat (45) @(negedge clock);
    check("t2_abort_no_done", 32'(done_cnt[0] - d0), 0);
    check("t2_abort_stays_idle", 32'(seq_state[0]), 32'(S_IDLE));

    // Fresh job of nine 1x1 pairs -> 9.
    start_job(0);
    for (int i = 0; i < 9; i++) feed_pair(0, 8'd1, 8'd1);
    wait_state(0, S_DONE, "t2_ones_done");
    check("t2_ones_result", 32'(result[0]), 9);
    check("t2_ones_valid", 32'(result_valid[0]), 1);

    // Fifteen 255x255 terms -> 975375 without overflow.
    b0 = begin_cnt[1];
    start_job(1);
    for (int i = 0; i < 15; i++) feed_pair(1, 8'd255, 8'd255);
    wait_state(1, S_DONE, "t3_done");
    @(negedge clock);
    check("t3_result", 32'(result[1]), 975375);
    check("t3_carry", 32'(acc_carry[1]), 0);
    check("t3_begin_count", 32'(begin_cnt[1] - b0), 15);

    // 16-bit accumulator, two 255x255 terms -> wraps to 64514 with carry.
    start_job(2);
    for (int i = 0; i < 2; i++) feed_pair(2, 8'd255, 8'd255);
    wait_state(2, S_DONE, "t4_done");
    check("t4_result", 32'(result[2]), 64514);
    check("t4_carry", 32'(acc_carry[2]), 1);
    start_job(2);
    check("t4_clear_carry", 32'(acc_carry[2]), 0);
    check("t4_clear_result", 32'(result[2]), 0);
    feed_pair(2, 8'd3, 8'd5);
    feed_pair(2, 8'd7, 8'd9);
    wait_state(2, S_DONE, "t4_second_done");
    check("t4_second_result", 32'(result[2]), 78);
    check("t4_second_carry", 32'(acc_carry[2]), 0);

    // Asynchronous reset in the middle of an ACCUM cycle.
    start_job(0);
    feed_pair(0, 8'd4, 8'd4);
    wait_state(0, S_ACCUM, "t5_first_accum");
    feed_pair(0, 8'd5, 8'd5);
    wait_state(0, S_ACCUM, "t5_second_accum");
    check("t5_pre_reset_result", 32'(result[0]), 16);
    #2 reset = 1'b1;
    #1;
    check("t5_reset_result", 32'(result[0]), 0);
    check("t5_reset_outs",
          32'({acc_carry[0], result_valid[0], done[0], busy[0], op_ready[0], mul_begin[0]}), 0);
    check("t5_reset_mul_ops", 32'({mul_a[0], mul_b[0]}), 0);
    check("t5_reset_state", 32'(seq_state[0]), 32'(S_IDLE));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t5_after_reset_state", 32'(seq_state[0]), 32'(S_IDLE));
    check("t5_after_reset_begin", 32'(mul_begin[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
